plic_target_mc: RTL and testbench
=================================

// Module: plic_target_mc
// PURPOSE
//  Multi-context PLIC core: per-source gateways (level/edge), pending and in-service tracking, and per-context
//  max-priority arbitration with threshold. Implements the claim/complete handshake for each hart context.
//  Sits between the PLIC register file (IE, priority, threshold, claim/complete regs) and the hart interrupt lines.
// PARAMETERS
//  SRC_CNT    32   number of interrupt sources; source IDs 1..SRC_CNT, ID 0 = "no interrupt"
//  PRIO_W     3    priority width; priority 0 = never interrupts
//  CTX_CNT    2    number of targets (hart/privilege contexts)
//  EDGE_MASK  '0   SRC_CNT bits; bit i=1 -> source i+1 edge-triggered, 0 -> level-triggered
//  SRC_W      $clog2(SRC_CNT+1)  derived ID width, not overridable
// PORTS
//  clk              in   1                 clock
//  rst_n            in   1                 asynchronous active-low reset
//  irq_src_i        in   SRC_CNT           raw source lines, already synchronous to clk
//  regs_prio_i      in   SRC_CNT*PRIO_W    per-source priority
//  regs_ie_i        in   CTX_CNT*SRC_CNT   per-context enable
//  regs_prio_th_i   in   CTX_CNT*PRIO_W    per-context threshold
//  claim_req_i      in   CTX_CNT           1-cycle claim strobe per context (claim-register read)
//  complete_req_i   in   CTX_CNT           1-cycle complete strobe per context (complete-register write)
//  complete_idx_i   in   CTX_CNT*SRC_W     ID being completed
//  claim_idx_o      out  CTX_CNT*SRC_W     ID granted to the claim, valid with claim_vld_o
//  claim_vld_o      out  CTX_CNT           1 cycle after claim_req_i
//  irq_req_o        out  CTX_CNT           registered interrupt request to hart
//  irq_idx_o        out  CTX_CNT*SRC_W     registered best candidate ID (0 if none)
//  irq_pending_o    out  SRC_CNT           pending bits, for the register-file pending array
// BEHAVIOUR
//  Reset: all pending, in_service, edge_hold, src_q flops 0; all outputs 0.
//  Gateway, per source s:
//   level: set pending when irq_src_i[s]=1 and !pending and !in_service.
//   edge: rise = irq_src_i[s] & !src_q[s]. If !pending & !in_service: set pending. If pending: rise is merged/dropped.
//    If in_service: set edge_hold (1 deep). On completion, edge_hold moves to pending in the same update; hold clears.
//  Arbitration, per context c (combinational on current pending, registered to outputs):
//   candidate = pending & ie[c] & prio > th[c]. Select max prio; ties -> lowest ID. ID = s+1.
//   irq_req_o/irq_idx_o register this result: 1-cycle latency from any input/pending change.
//  Claim, context c, claim_req_i[c]=1 in cycle T:
//   Grant ID = irq_idx_o[c] (the registered value) iff that source is still pending after lower-numbered contexts'
//    same-cycle claims, else grant 0. Lowest context index wins a simultaneous claim of the same ID.
//   Grant: pending cleared and in_service set at T+1. claim_idx_o/claim_vld_o valid at T+1 for exactly one cycle.
//   irq_req_o[c] drops at T+2 at the latest when no other candidate remains. Claim with irq_idx_o=0 returns 0.
//  Complete, context c: clear in_service[ID-1] iff 1<=ID<=SRC_CNT and in_service set. Otherwise silently ignore,
//   including ID 0 and out-of-range IDs. The ID need not be enabled for c.
//   Level source still asserted re-pends the cycle after in_service clears, never the same cycle.
//  Same-cycle claim and complete of the same ID by different contexts: complete is applied first, then the claim.
//   The claim is evaluated on pending only, so the result is well defined.
//  Priority or enable changes never disturb pending or in_service; they affect arbitration only.
//  Priority 0 and threshold = max priority mask all interrupts for that source/context.
//  Reset mid-claim drops the outstanding grant; no claim_vld_o is produced after reset.
// STRUCTURE
//  plic_pkg: SRC_W function/localparam, typedefs src_id_t, prio_t, per-context arb result struct {req, idx}.
//  Sub-module plic_gateway (one instance per source, generate loop): src_q, pending, in_service, edge_hold flops.
//   Inputs: mode, src, claim_hit, complete_hit. Output: pending.
//  Top level: CTX_CNT arbiters (linear or tree compare), claim resolution loop in context order,
//   complete decode, output flops.
// TESTING
//  1 level src 3, prio 2, ie ctx0, th 0 -> irq_req_o[0]=1, irq_idx_o[0]=3 one cycle later. Claim -> claim_idx_o=3,
//    pending[2]=0, req drops. Complete(3) with src high -> re-pend next cycle.
//  2 srcs 5 and 9 both prio 4 -> idx 5 (tie to lowest). Raise prio9 to 6 -> idx 9 next cycle. Set th0=6 -> irq_req_o[0]=0.
//  3 edge src 7: two pulses before claim -> one claim, then no re-pend. Pulse while in_service -> pending=1 the cycle
//    after complete(7).
//  4 ctx0 and ctx1 both enabled for src 4, claim same cycle -> ctx0 gets 4, ctx1 gets 0. Both irq_req_o fall.
//  5 complete(0), complete(SRC_CNT+1), complete of a non-in-service ID -> no state change. Claim with nothing pending -> 0.
//  6 assert rst_n low during the claim cycle -> all outputs 0. Level source still high pends again after reset release.

Source files
------------

// File: rtl/plic_pkg.sv
// Shared types and helpers for the multi-context PLIC core.
// The parameterized top derives its own widths from src_w(); the typedefs here describe the default build.
package plic_pkg;

    function automatic int src_w(input int src_cnt);
        return $clog2(src_cnt + 1);
    endfunction

    localparam int DEF_SRC_CNT = 32;
    localparam int DEF_PRIO_W  = 3;
    localparam int DEF_SRC_W   = src_w(DEF_SRC_CNT);

    typedef logic [DEF_SRC_W-1:0]  src_id_t;
    typedef logic [DEF_PRIO_W-1:0] prio_t;

    typedef struct packed {
        logic    req;
        src_id_t idx;
    } arb_res_t;

    typedef enum logic {
        GW_LEVEL = 1'b0,
        GW_EDGE  = 1'b1
    } gw_mode_e;

endpackage

// File: rtl/plic_gateway.sv
// Per-source gateway: turns a raw line into pending / in-service state with claim and complete handshakes.
module plic_gateway
    import plic_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  gw_mode_e mode,
    input  logic     src,
    input  logic     claim_hit,
    input  logic     complete_hit,
    output logic     pending
);

    logic src_q, in_service, edge_hold;
    logic pending_n, in_service_n, edge_hold_n;
    logic rise, done;

    assign rise = src & ~src_q;
    assign done = complete_hit & in_service;

    always_comb begin
        pending_n    = pending;
        in_service_n = in_service;
        edge_hold_n  = edge_hold;
        if (claim_hit) begin
            pending_n    = 1'b0;
            in_service_n = 1'b1;
        end
        if (done) begin
            in_service_n = 1'b0;
            // A held edge (or one arriving right now) becomes the next pending request.
            if (mode == GW_EDGE) begin
                pending_n   = edge_hold | rise;
                edge_hold_n = 1'b0;
            end
        end else if (mode == GW_EDGE) begin
            if (rise && in_service)
                edge_hold_n = 1'b1;
            else if (rise && !pending)
                pending_n = 1'b1;
        end else if (src && !pending && !in_service) begin
            pending_n = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q      <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
            edge_hold  <= 1'b0;
        end else begin
            src_q      <= src;
            pending    <= pending_n;
            in_service <= in_service_n;
            edge_hold  <= edge_hold_n;
        end
    end

endmodule

// File: rtl/plic_target_mc.sv
// Multi-context PLIC core: source gateways, per-context max-priority arbitration with threshold,
// and claim/complete resolution in context order.
module plic_target_mc
    import plic_pkg::*;
#(
    parameter int                 SRC_CNT   = 32,
    parameter int                 PRIO_W    = 3,
    parameter int                 CTX_CNT   = 2,
    parameter logic [SRC_CNT-1:0] EDGE_MASK = '0,
    localparam int                SRC_W     = src_w(SRC_CNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SRC_CNT-1:0]         irq_src_i,
    input  logic [SRC_CNT*PRIO_W-1:0]  regs_prio_i,
    input  logic [CTX_CNT*SRC_CNT-1:0] regs_ie_i,
    input  logic [CTX_CNT*PRIO_W-1:0]  regs_prio_th_i,
    input  logic [CTX_CNT-1:0]         claim_req_i,
    input  logic [CTX_CNT-1:0]         complete_req_i,
    input  logic [CTX_CNT*SRC_W-1:0]   complete_idx_i,
    output logic [CTX_CNT*SRC_W-1:0]   claim_idx_o,
    output logic [CTX_CNT-1:0]         claim_vld_o,
    output logic [CTX_CNT-1:0]         irq_req_o,
    output logic [CTX_CNT*SRC_W-1:0]   irq_idx_o,
    output logic [SRC_CNT-1:0]         irq_pending_o
);

    typedef struct packed {
        logic             req;
        logic [SRC_W-1:0] idx;
    } arb_t;

    logic [SRC_CNT-1:0]              pending, claim_hit, complete_hit;
    logic [CTX_CNT-1:0][PRIO_W-1:0]  best_prio;
    arb_t [CTX_CNT-1:0]              arb, arb_q;
    logic [CTX_CNT-1:0][SRC_W-1:0]   grant_idx, claim_idx_q;
    logic [CTX_CNT-1:0]              claim_vld_q;

    for (genvar s = 0; s < SRC_CNT; s++) begin : gen_gw
        plic_gateway u_gw (
            .clk          (clk),
            .rst_n        (rst_n),
            .mode         (EDGE_MASK[s] ? GW_EDGE : GW_LEVEL),
            .src          (irq_src_i[s]),
            .claim_hit    (claim_hit[s]),
            .complete_hit (complete_hit[s]),
            .pending      (pending[s])
        );
    end

    // Seeding the running max with the threshold folds "prio > th" into the compare;
    // strict '>' keeps the lowest ID on ties.
    always_comb begin
        for (int c = 0; c < CTX_CNT; c++) begin
            best_prio[c] = regs_prio_th_i[c*PRIO_W +: PRIO_W];
            arb[c]       = '0;
            for (int s = 0; s < SRC_CNT; s++) begin
                if (pending[s] && regs_ie_i[c*SRC_CNT+s] &&
                    regs_prio_i[s*PRIO_W +: PRIO_W] > best_prio[c]) begin
                    best_prio[c] = regs_prio_i[s*PRIO_W +: PRIO_W];
                    arb[c].req   = 1'b1;
                    arb[c].idx   = SRC_W'(s + 1);
                end
            end
        end
    end

    // Claims resolve in context order so the lowest context takes a contested ID.
    always_comb begin
        claim_hit = '0;
        grant_idx = '0;
        for (int c = 0; c < CTX_CNT; c++) begin
            for (int s = 0; s < SRC_CNT; s++) begin
                if (claim_req_i[c] && arb_q[c].idx == SRC_W'(s + 1) && pending[s] && !claim_hit[s]) begin
                    claim_hit[s] = 1'b1;
                    grant_idx[c] = arb_q[c].idx;
                end
            end
        end
    end

    always_comb begin
        complete_hit = '0;
        for (int s = 0; s < SRC_CNT; s++)
            for (int c = 0; c < CTX_CNT; c++)
                if (complete_req_i[c] && complete_idx_i[c*SRC_W +: SRC_W] == SRC_W'(s + 1))
                    complete_hit[s] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_q       <= '0;
            claim_vld_q <= '0;
            claim_idx_q <= '0;
        end else begin
            arb_q       <= arb;
            claim_vld_q <= claim_req_i;
            claim_idx_q <= grant_idx;
        end
    end

    always_comb begin
        for (int c = 0; c < CTX_CNT; c++) begin
            irq_req_o[c]                 = arb_q[c].req;
            irq_idx_o[c*SRC_W +: SRC_W]  = arb_q[c].idx;
        end
    end

    assign claim_idx_o   = claim_idx_q;
    assign claim_vld_o   = claim_vld_q;
    assign irq_pending_o = pending;

endmodule

// File: tb/tb_plic_target_mc.sv
// Directed spec scenarios plus a random phase, all checked every cycle against a behavioural PLIC model.
module tb_plic_target_mc;

    localparam int N  = 32;
    localparam int PW = 3;
    localparam int C  = 2;
    localparam int SW = 6;
    localparam logic [N-1:0] EM = 32'hFFFF_0040;  // source 7 and 17..32 edge-triggered

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src;
    logic [N*PW-1:0] prio;
    logic [C*N-1:0]  ie;
    logic [C*PW-1:0] th;
    logic [C-1:0]    creq, kreq;
    logic [C*SW-1:0] kidx;
    logic [C*SW-1:0] cidx, idx;
    logic [C-1:0]    cvld, req;
    logic [N-1:0]    pend;

    always #5 clk = ~clk;

    plic_target_mc #(.SRC_CNT(N), .PRIO_W(PW), .CTX_CNT(C), .EDGE_MASK(EM)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_src_i      (src),
        .regs_prio_i    (prio),
        .regs_ie_i      (ie),
        .regs_prio_th_i (th),
        .claim_req_i    (creq),
        .complete_req_i (kreq),
        .complete_idx_i (kidx),
        .claim_idx_o    (cidx),
        .claim_vld_o    (cvld),
        .irq_req_o      (req),
        .irq_idx_o      (idx),
        .irq_pending_o  (pend)
    );

    // Reference state: what the spec says each source and context should hold.
    logic [N-1:0]    m_pend, m_is, m_hold, m_srcq;
    logic [C-1:0]    m_req, m_cvld;
    logic [C*SW-1:0] m_idx, m_cidx;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".req"},  64'(req),  64'(m_req));
        chk({tag, ".idx"},  64'(idx),  64'(m_idx));
        chk({tag, ".cvld"}, 64'(cvld), 64'(m_cvld));
        chk({tag, ".cidx"}, 64'(cidx), 64'(m_cidx));
        chk({tag, ".pend"}, 64'(pend), 64'(m_pend));
    endtask

    function automatic int prio_of(input int s);
        return int'(prio[s*PW +: PW]);
    endfunction

    // One clock: predict the next state from the spec rules, clock the DUT, compare.
    task automatic tick(input string tag);
        logic [N-1:0]    np, ni, nh, granted, done;
        logic [C-1:0]    nreq;
        logic [C*SW-1:0] nidx, ncidx;
        int best, id;
        nidx = '0; ncidx = '0; nreq = '0; granted = '0; done = '0;
        for (int c = 0; c < C; c++) begin
            best = int'(th[c*PW +: PW]);
            for (int s = 0; s < N; s++)
                if (m_pend[s] && ie[c*N+s] && prio_of(s) > best) begin
                    best = prio_of(s);
                    nidx[c*SW +: SW] = SW'(s + 1);
                    nreq[c] = 1'b1;
                end
        end
        for (int c = 0; c < C; c++) begin
            id = int'(m_idx[c*SW +: SW]);
            if (creq[c] && id != 0 && m_pend[id-1] && !granted[id-1]) begin
                granted[id-1] = 1'b1;
                ncidx[c*SW +: SW] = SW'(id);
            end
            id = int'(kidx[c*SW +: SW]);
            if (kreq[c] && id >= 1 && id <= N && m_is[id-1]) done[id-1] = 1'b1;
        end
        np = m_pend; ni = m_is; nh = m_hold;
        for (int s = 0; s < N; s++) begin
            logic rise;
            rise = src[s] & ~m_srcq[s];
            if (granted[s]) begin np[s] = 1'b0; ni[s] = 1'b1; end
            if (done[s]) begin
                ni[s] = 1'b0;
                if (EM[s]) begin np[s] = m_hold[s] | rise; nh[s] = 1'b0; end
            end else if (EM[s]) begin
                if (rise && m_is[s]) nh[s] = 1'b1;
                else if (rise && !m_pend[s]) np[s] = 1'b1;
            end else if (src[s] && !m_pend[s] && !m_is[s]) begin
                np[s] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        m_pend = np; m_is = ni; m_hold = nh; m_srcq = src;
        m_req = nreq; m_idx = nidx; m_cvld = creq; m_cidx = ncidx;
        chk_all(tag);
    endtask

    task automatic do_reset();
        src = '0; prio = '0; ie = '0; th = '0; creq = '0; kreq = '0; kidx = '0;
        rst_n = 1'b0;
        m_pend = '0; m_is = '0; m_hold = '0; m_srcq = '0;
        m_req = '0; m_idx = '0; m_cvld = '0; m_cidx = '0;
        @(posedge clk);
        #1;
        chk_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // 1: level source 3
        prio[2*PW +: PW] = 3'd2; ie[2] = 1'b1; src[2] = 1'b1;
        tick("t1.pend");
        chk("t1.pend3", 64'(pend[2]), 64'd1);
        tick("t1.arb");
        chk("t1.req", 64'(req[0]), 64'd1);
        chk("t1.idx", 64'(idx[SW-1:0]), 64'd3);
        creq[0] = 1'b1; tick("t1.claim"); creq = '0;
        chk("t1.cidx", 64'(cidx[SW-1:0]), 64'd3);
        chk("t1.cvld", 64'(cvld), 64'd1);
        chk("t1.pcl", 64'(pend[2]), 64'd0);
        tick("t1.drop");
        chk("t1.reqdrop", 64'(req[0]), 64'd0);
        kreq[0] = 1'b1; kidx[SW-1:0] = 6'd3; tick("t1.cmp"); kreq = '0;
        chk("t1.nosame", 64'(pend[2]), 64'd0);
        tick("t1.repend");
        chk("t1.repend3", 64'(pend[2]), 64'd1);

        // 2: tie break, priority raise, threshold mask
        do_reset();
        prio[4*PW +: PW] = 3'd4; prio[8*PW +: PW] = 3'd4;
        ie[4] = 1'b1; ie[8] = 1'b1; src[4] = 1'b1; src[8] = 1'b1;
        tick("t2.a"); tick("t2.b");
        chk("t2.tie", 64'(idx[SW-1:0]), 64'd5);
        prio[8*PW +: PW] = 3'd6; tick("t2.c");
        chk("t2.raise", 64'(idx[SW-1:0]), 64'd9);
        th[PW-1:0] = 3'd6; tick("t2.d");
        chk("t2.th", 64'(req[0]), 64'd0);
        prio[4*PW +: PW] = 3'd0; prio[8*PW +: PW] = 3'd0; th = '0;
        tick("t2.e");
        chk("t2.p0", 64'(req[0]), 64'd0);
        chk("t2.keep", 64'(pend[8]), 64'd1);

        // 3: edge source 7
        do_reset();
        prio[6*PW +: PW] = 3'd1; ie[6] = 1'b1;
        src[6] = 1'b1; tick("t3.p1"); src[6] = 1'b0; tick("t3.p1b");
        src[6] = 1'b1; tick("t3.p2"); src[6] = 1'b0; tick("t3.p2b");
        creq[0] = 1'b1; tick("t3.claim"); creq = '0;
        chk("t3.cidx", 64'(cidx[SW-1:0]), 64'd7);
        tick("t3.x"); tick("t3.y");
        chk("t3.nore", 64'(pend[6]), 64'd0);
        chk("t3.req0", 64'(req[0]), 64'd0);
        src[6] = 1'b1; tick("t3.p3"); src[6] = 1'b0; tick("t3.p3b");
        chk("t3.held", 64'(pend[6]), 64'd0);
        kreq[0] = 1'b1; kidx[SW-1:0] = 6'd7; tick("t3.cmp"); kreq = '0;
        chk("t3.hold2p", 64'(pend[6]), 64'd1);

        // 4/5: contested claim, ignored completes, empty claim
        do_reset();
        prio[3*PW +: PW] = 3'd3; ie[3] = 1'b1; ie[N+3] = 1'b1; src[3] = 1'b1;
        tick("t4.a"); tick("t4.b");
        chk("t4.req", 64'(req), 64'd3);
        creq = 2'b11; tick("t4.claim"); creq = '0;
        chk("t4.c0", 64'(cidx[SW-1:0]), 64'd4);
        chk("t4.c1", 64'(cidx[2*SW-1:SW]), 64'd0);
        tick("t4.fall");
        chk("t4.reqfall", 64'(req), 64'd0);
        kreq = 2'b11; kidx = {6'd33, 6'd0}; tick("t5.bad"); kreq = '0;
        kreq[1] = 1'b1; kidx[2*SW-1:SW] = 6'd9; tick("t5.nis"); kreq = '0;
        tick("t5.still");
        chk("t5.insvc", 64'(pend[3]), 64'd0);
        creq[1] = 1'b1; tick("t5.empty"); creq = '0;
        chk("t5.cvld", 64'(cvld), 64'd2);
        chk("t5.cidx", 64'(cidx[2*SW-1:SW]), 64'd0);

        // 6: reset during the claim cycle
        do_reset();
        prio[1*PW +: PW] = 3'd1; ie[1] = 1'b1; src[1] = 1'b1;
        tick("t6.a"); tick("t6.b");
        creq[0] = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6.req", 64'(req), 64'd0);
        chk("t6.pend", 64'(pend), 64'd0);
        @(posedge clk); #1;
        chk("t6.cvld", 64'(cvld), 64'd0);
        creq = '0; rst_n = 1'b1;
        m_pend = '0; m_is = '0; m_hold = '0; m_srcq = '0;
        m_req = '0; m_idx = '0; m_cvld = '0; m_cidx = '0;
        tick("t6.r1"); tick("t6.r2");
        chk("t6.again", 64'(req[0]), 64'd1);

        // Random traffic against the model
        do_reset();
        for (int s = 0; s < N; s++) prio[s*PW +: PW] = PW'($urandom_range(0, 7));
        ie = {$urandom, $urandom};
        th = {3'($urandom_range(0, 2)), 3'($urandom_range(0, 2))};
        for (int i = 0; i < 600; i++) begin
            src  = src ^ ($urandom & $urandom & $urandom);
            creq = C'($urandom & $urandom);
            kreq = C'($urandom & $urandom);
            for (int c = 0; c < C; c++) begin
                int s;
                s = $urandom_range(0, N - 1);
                kidx[c*SW +: SW] = m_is[s] ? SW'(s + 1) : SW'($urandom_range(0, 40));
            end
            if ($urandom_range(0, 19) == 0)
                prio[$urandom_range(0, N - 1)*PW +: PW] = PW'($urandom_range(0, 7));
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
